// File: rtl/integ_window_ctrl.sv
// integ_window_ctrl: sequencer for one command-triggered integration window.
// It samples and holds sample_in every sample_period clocks and keeps the integrator enabled for
// window_len samples. It reports the window integral as integ_result minus the baseline captured
// before the window, so the integrator never has to be cleared.
//
// Ports:
//   clk, resetb              clock and asynchronous active-low reset
//   cmd_start, cmd_abort     single-cycle window request / abort request
//   sample_period            clocks per sample; window_len is the number of samples per window
//   sample_in                raw sensor value
//   integ_result             integrator output (integral_result)
//   integ_start              integrator enable (start_integration)
//   integ_signal             held sample driven to the integrator (signal_input)
//   busy                     high whenever a window is in progress
//   result_data              last window integral, modulo 2^N
//   result_valid             one-cycle pulse when result_data is updated
//   aborted, cfg_err         one-cycle pulses: abort taken, start rejected (zero period/length)
module integ_window_ctrl #(
  parameter int unsigned N          = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  input  logic [CNT_W-1:0] sample_period,
  input  logic [CNT_W-1:0] window_len,
  input  logic [N-1:0]     sample_in,
  input  logic [N-1:0]     integ_result,
  output logic             integ_start,
  output logic [N-1:0]     integ_signal,
  output logic             busy,
  output logic [N-1:0]     result_data,
  output logic             result_valid,
  output logic             aborted,
  output logic             cfg_err
);

  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {StIdle, StArm, StRun, StSettle, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] p_q;
  logic [CNT_W-1:0] k_q;
  logic [SW-1:0]    s_cnt_q;
  logic [N-1:0]     baseline_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= StIdle;
      per_q        <= '0;
      len_q        <= '0;
      p_q          <= '0;
      k_q          <= '0;
      s_cnt_q      <= '0;
      baseline_q   <= '0;
      integ_start  <= 1'b0;
      integ_signal <= '0;
      busy         <= 1'b0;
      result_data  <= '0;
      result_valid <= 1'b0;
      aborted      <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      aborted      <= 1'b0;
      cfg_err      <= 1'b0;
      // Abort only matters while a window is in progress; it beats a same-cycle start.
      if (cmd_abort && (state_q == StArm || state_q == StRun || state_q == StSettle)) begin
        state_q     <= StIdle;
        busy        <= 1'b0;
        integ_start <= 1'b0;
        aborted     <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cmd_start) begin
              if (sample_period == '0 || window_len == '0) begin
                cfg_err <= 1'b1;
              end else begin
                per_q   <= sample_period;
                len_q   <= window_len;
                busy    <= 1'b1;
                state_q <= StArm;
              end
            end
          end
          StArm: begin
            baseline_q   <= integ_result;
            p_q          <= '0;
            k_q          <= '0;
            // Load the first sample here so it is already on integ_signal in the first RUN
            // cycle (p == 0).
            integ_signal <= sample_in;
            integ_start  <= 1'b1;
            state_q      <= StRun;
          end
          StRun: begin
            if (p_q == per_q - CNT_W'(1)) begin
              p_q <= '0;
              if (k_q == len_q - CNT_W'(1)) begin
                integ_start <= 1'b0;
                s_cnt_q     <= '0;
                state_q     <= StSettle;
              end else begin
                k_q          <= k_q + CNT_W'(1);
                integ_signal <= sample_in;
              end
            end else begin
              p_q <= p_q + CNT_W'(1);
            end
          end
          StSettle: begin
            // Give the integrator time to fold the last sample into integ_result.
            if (s_cnt_q == SettleLast) begin
              result_data  <= integ_result - baseline_q;
              result_valid <= 1'b1;
              state_q      <= StDone;
            end else begin
              s_cnt_q <= s_cnt_q + SW'(1);
            end
          end
          StDone: begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
